// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder: FSM encoding and datapath widths.
package mem_responder_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned CntW     = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Processor-side request/response bus of the memory responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Synchronous RAM: port A single read/write for service, port B free-running debug read.
module mem_responder_mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Array contents survive reset; callers gate a_en with reset themselves.
  always_ff @(posedge clk) begin
    if (a_en && a_we) begin
      mem_q[a_addr] <= a_wdata;
    end
  end

  // Read-before-write: port B sees the pre-write word on a colliding edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      b_rdata <= mem_q[b_addr];
      if (a_en && !a_we) begin
        a_rdata <= mem_q[a_addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, waits WAIT_CYCLES, then pulses a one-cycle response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  if (WAIT_CYCLES > 15) begin : g_wait_check
    $error("WAIT_CYCLES must be in 0..15");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == StIdle && bus.req_valid) begin
      wr_q    <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cnt_d   = CntW'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES != 0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so bypass the latches.
  always_comb begin
    bus.req_ready = rst && (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    mem_en        = rst && (state_d == StResp);
    mem_we        = (state_q == StIdle) ? bus.req_write : wr_q;
    mem_addr      = (state_q == StIdle) ? bus.req_addr  : addr_q;
    mem_wdata     = (state_q == StIdle) ? bus.req_wdata : wdata_q;
  end

  assign bus.rsp_rdata = mem_rdata;

  mem_responder_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .a_en    (mem_en),
    .a_we    (mem_we),
    .a_addr  (mem_addr),
    .a_wdata (mem_wdata),
    .a_rdata (mem_rdata),
    .b_addr  (dbg_addr),
    .b_rdata (dbg_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  dbg_addr2 = 8'h00;
  logic [7:0]  dbg_addr0 = 8'h00;
  logic [15:0] dbg_data2;
  logic [15:0] dbg_data0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(8), .DATA_W(16)) b2 ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(16)) b0 ();

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (b2.slave),
    .dbg_addr (dbg_addr2),
    .dbg_data (dbg_data2)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (b0.slave),
    .dbg_addr (dbg_addr0),
    .dbg_data (dbg_data0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the selected instance; lat counts cycles from acceptance edge to rsp.
  task automatic issue(input bit z, input bit wr, input logic [7:0] addr,
                       input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
    int n;
    n = 0;
    while (!(z ? b0.req_ready : b2.req_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL issue_ready_timeout: req_ready stayed 0, required 1");
    end
    if (z) begin
      b0.req_valid = 1'b1; b0.req_write = wr; b0.req_addr = addr; b0.req_wdata = wdata;
    end else begin
      b2.req_valid = 1'b1; b2.req_write = wr; b2.req_addr = addr; b2.req_wdata = wdata;
    end
    tick();
    b0.req_valid = 1'b0;
    b2.req_valid = 1'b0;
    lat = 1;
    while (!(z ? b0.rsp_valid : b2.rsp_valid) && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) begin
      errors++;
      $display("FAIL issue_rsp_timeout: rsp_valid never seen, required a pulse");
    end
    rdata = z ? b0.rsp_rdata : b2.rsp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (b2.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b, required 0", b2.req_ready);
    end
    checks++;
    if (b2.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b, required 0", b2.rsp_valid);
    end
    checks++;
    if (b2.rsp_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rsp_rdata: got %h, required 0000", b2.rsp_rdata);
    end
    checks++;
    if (dbg_data2 !== 16'h0000) begin
      errors++; $display("FAIL reset_dbg_data: got %h, required 0000", dbg_data2);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b2.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b, required 1", b2.req_ready);
    end
    checks++;
    if (b0.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after_w0: got %b, required 1", b0.req_ready);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [15:0] rd;
    issue(1'b0, 1'b1, 8'h10, 16'hBEEF, lat, rd);
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL write_latency: got %0d, required 3", lat);
    end
    tick();
    checks++;
    if (b2.rsp_valid !== 1'b0 || b2.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_pulse_width: valid=%b ready=%b, required valid=0 ready=1",
               b2.rsp_valid, b2.req_ready);
    end
    issue(1'b0, 1'b0, 8'h10, 16'h0000, lat, rd);
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL read_latency: got %0d, required 3", lat);
    end
    checks++;
    if (rd !== 16'hBEEF) begin
      errors++; $display("FAIL read_data: got %h, required BEEF", rd);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    int lat;
    logic [15:0] rd;
    issue(1'b1, 1'b1, 8'h00, 16'h1234, lat, rd);
    tick();
    issue(1'b1, 1'b0, 8'h00, 16'h0000, lat, rd);
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL w0_latency: got %0d, required 1", lat);
    end
    checks++;
    if (rd !== 16'h1234) begin
      errors++; $display("FAIL w0_read_data: got %h, required 1234", rd);
    end
    checks++;
    if (b0.req_ready !== 1'b0) begin
      errors++; $display("FAIL w0_ready_in_resp: got %b, required 0", b0.req_ready);
    end
    tick();
    checks++;
    if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL w0_ready_return: ready=%b valid=%b, required ready=1 valid=0",
               b0.req_ready, b0.rsp_valid);
    end
    checks++;
    if (dbg_data0 !== 16'h1234) begin
      errors++; $display("FAIL w0_dbg_data: got %h, required 1234", dbg_data0);
    end
  endtask

  task automatic test_held_request();
    logic [11:0] rdy_seen, rsp_seen;
    b2.req_valid = 1'b1;
    b2.req_write = 1'b0;
    b2.req_addr  = 8'hFF;
    for (int k = 1; k <= 12; k++) begin
      tick();
      rdy_seen[k-1] = b2.req_ready;
      rsp_seen[k-1] = b2.rsp_valid;
    end
    b2.req_valid = 1'b0;
    // Cycle k after start: RESP when k%4==3, IDLE when k%4==0.
    checks++;
    if (rdy_seen !== 12'b1000_1000_1000) begin
      errors++; $display("FAIL held_ready_pattern: got %b, required 100010001000", rdy_seen);
    end
    checks++;
    if (rsp_seen !== 12'b0100_0100_0100) begin
      errors++; $display("FAIL held_rsp_pattern: got %b, required 010001000100", rsp_seen);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [15:0] rd;
    bit seen;
    issue(1'b0, 1'b1, 8'h20, 16'h5555, lat, rd);
    tick();
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 8'h20; b2.req_wdata = 16'hAAAA;
    tick();
    b2.req_valid = 1'b0;
    tick();
    // Reset lands on the would-be commit edge.
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen |= b2.rsp_valid;
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen |= b2.rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_drop_rsp: rsp_valid seen=%b, required 0", seen);
    end
    issue(1'b0, 1'b0, 8'h20, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h5555) begin
      errors++; $display("FAIL reset_no_commit: got %h, required 5555", rd);
    end
    tick();
  endtask

  task automatic test_dbg_collision();
    int lat;
    logic [15:0] rd;
    issue(1'b0, 1'b1, 8'h30, 16'h1111, lat, rd);
    tick();
    dbg_addr2 = 8'h30;
    issue(1'b0, 1'b1, 8'h30, 16'hCAFE, lat, rd);
    checks++;
    if (dbg_data2 !== 16'h1111) begin
      errors++; $display("FAIL dbg_old_data: got %h, required 1111", dbg_data2);
    end
    tick();
    checks++;
    if (dbg_data2 !== 16'hCAFE) begin
      errors++; $display("FAIL dbg_new_data: got %h, required CAFE", dbg_data2);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] rd;
    issue(1'b0, 1'b1, 8'h40, 16'h0F0F, lat, rd);
    tick();
    issue(1'b0, 1'b0, 8'h40, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h0F0F) begin
      errors++; $display("FAIL b2b_read_new: got %h, required 0F0F", rd);
    end
    issue(1'b0, 1'b0, 8'h10, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'hBEEF) begin
      errors++; $display("FAIL b2b_read_other: got %h, required BEEF", rd);
    end
    tick();
  endtask

  initial begin
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    #1;
    test_reset();
    test_write_read();
    test_zero_wait();
    test_held_request();
    test_reset_mid_write();
    test_dbg_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the processor's unified instruction/data memory interface. It accepts the processor's read and write requests over a valid/ready handshake. Each request is serviced after a programmable number of wait states and answered with a one-cycle response pulse. A registered debug read port lets a bench inspect any word without disturbing the processor's traffic.

Parameters:
ADDR_W, 8, word-address width; depth is 2**ADDR_W words.
DATA_W, 16, data word width.
WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
req_valid  input  1  processor presents a request.
req_write  input  1  1 = write, 0 = read; qualified by req_valid.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data.
req_ready  output  1  responder can accept a request this cycle.
rsp_valid  output  1  one-cycle pulse: read data valid, or write done.
rsp_rdata  output  DATA_W  read data; holds last value otherwise.
dbg_addr  input  ADDR_W  debug read address.
dbg_data  output  DATA_W  registered debug read data.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; req_ready=0 during reset, 1 from the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, dbg_data=0, wait counter=0.
  - Memory array is not cleared.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write/addr/wdata; load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter==1, go to RESP.
- RESP transition edge:
  - Read: array[addr] is registered into rsp_rdata.
  - Write: array[addr]<=wdata is committed.
- RESP state:
  - rsp_valid=1 for exactly this cycle; req_ready=0; next state IDLE.
- Latency: response exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- Back-to-back: next request can be accepted at earliest one cycle after RESP. Throughput is one request per WAIT_CYCLES+2 cycles.
- No response backpressure: rsp_valid is never stalled.
- Inputs outside IDLE are ignored. A request held across WAIT/RESP is accepted again in IDLE.
- Reset mid-operation:
  - An in-flight request is dropped; no rsp_valid.
  - A write not yet committed is not performed.
- Address wrap: full 2**ADDR_W range is valid; no out-of-range case.
- Debug port:
  - dbg_data <= array[dbg_addr] every cycle, one-cycle latency, independent of the FSM.
  - Same-edge write to the same address: dbg_data returns old data (read-before-write).
  - The following cycle returns the new data.
- Read of a just-written address in the next request returns the new data.
- Counter width: 4 bits. WAIT_CYCLES>15 is illegal; flag with an elaboration-time check.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the default DATA_W/ADDR_W constants used by the datapath.
- One sub-module is natural: mem_array, a single-write, two-read-port synchronous RAM. Port A is the service read/write; port B is the debug read.
- The FSM and counter live in mem_responder.

Test Plan:
- Reset with WAIT_CYCLES=2: hold rst=0 for 3 cycles, release -> rsp_valid=0, rsp_rdata=0, dbg_data=0, req_ready=1 from the first cycle after release.
- Write then read:
  - Write addr 8'h10 data 16'hBEEF -> rsp_valid pulses exactly 3 cycles after acceptance.
  - Read addr 8'h10 -> rsp_rdata=16'hBEEF with rsp_valid 3 cycles after acceptance.
- WAIT_CYCLES=0: read of preloaded addr 8'h00=16'h1234 -> rsp_valid and rsp_rdata=16'h1234 on the cycle after acceptance. req_ready returns 1 the cycle after that.
- Held request: req_valid held high continuously with addr 8'hFF -> accepted once per 4 cycles (WAIT_CYCLES=2). req_ready=0 in WAIT/RESP; no extra responses.
- Reset mid-write: accept a write of 16'hAAAA to 8'h20 (old 16'h5555), assert rst during WAIT -> no rsp_valid. Subsequent read of 8'h20 returns 16'h5555.
- Debug collision: dbg_addr=8'h30 while a write 16'hCAFE to 8'h30 commits -> dbg_data shows the old value that cycle and 16'hCAFE the next cycle.
